// File: rtl/mem_stage_lsu_pkg.sv
// Shared types, funct3/error codes and store-lane helpers
// for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd0;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        regwr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } mem_req_t;

  function automatic logic [3:0] st_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_SB:   st_be = 4'b0001 << off;
      F3_SH:   st_be = 4'b0011 << off;
      default: st_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_wdata(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    case (f3)
      F3_SB:   st_wdata = {4{d[7:0]}};
      F3_SH:   st_wdata = {2{d[15:0]}};
      default: st_wdata = d;
    endcase
  endfunction

  // Load and store codes coincide for W (2) and H (1); HU is 5.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_LW:         misaligned = (off != 2'd0);
      F3_LH, F3_LHU: misaligned = off[0];
      default:       misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic illegal_op(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3
  );
    illegal_op = (rd & wr)
               | (rd & ((f3 == 3'd3) | (f3 >= 3'd6)))
               | (wr & (f3 > 3'd2));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load lane select and sign/zero extension.
// Ports: i_rdata word, i_off byte offset, i_f3 width -> o_data.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_b = i_rdata[7:0];
      2'd1: w_b = i_rdata[15:8];
      2'd2: w_b = i_rdata[23:16];
      2'd3: w_b = i_rdata[31:24];
    endcase
    w_h = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_f3)
      F3_LB:   o_data = {{24{w_b[7]}}, w_b};
      F3_LH:   o_data = {{16{w_h[15]}}, w_h};
      F3_LBU:  o_data = {24'd0, w_b};
      F3_LHU:  o_data = {16'd0, w_h};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU + MEM/WB register: ex_* in, dmem req/ack port,
// wb_* out, stall_o while an access is outstanding, err_o/err_code.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic        ex_regWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_s_data,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic        wb_memRead,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_o,
  output logic [1:0]  err_code
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  lsu_state_t      r_state;
  logic [CW-1:0]   r_wait;
  mem_req_t        r_req;

  logic            w_mem;
  logic            w_bad;
  logic            w_mis;
  logic            w_non;
  logic            w_ill;
  logic            w_mal;
  logic            w_go;
  logic [31:0]     w_ld;

  assign w_mem = ex_memRead | ex_memWrite;
  assign w_bad = illegal_op(ex_memRead, ex_memWrite, ex_funct3);
  assign w_mis = misaligned(ex_funct3, ex_alu_result[1:0]);

  // Mutually exclusive classes; illegal op outranks misalignment.
  assign w_non = ~w_mem;
  assign w_ill = w_mem & w_bad;
  assign w_mal = w_mem & ~w_bad & w_mis;
  assign w_go  = w_mem & ~w_bad & ~w_mis;

  mem_stage_lsu_load_align u_align (
    .i_rdata (dmem_rdata),
    .i_off   (r_req.addr[1:0]),
    .i_f3    (r_req.f3),
    .o_data  (w_ld)
  );

  assign stall_o    = (r_state == ACCESS);
  assign dmem_req   = (r_state == ACCESS);
  assign dmem_we    = r_req.we;
  assign dmem_addr  = {r_req.addr[31:2], 2'b00};
  assign dmem_wdata = r_req.wdata;
  assign dmem_be    = r_req.be;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_req       <= '0;
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_memRead  <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      err_o       <= 1'b0;
      err_code    <= '0;
    end else begin
      err_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          wb_valid    <= ex_valid;
          wb_regWrite <= 1'b0;
          wb_memRead  <= 1'b0;
          wb_rd       <= ex_rd;
          wb_data     <= ex_alu_result;
          if (ex_valid) begin
            unique case (1'b1)
              w_non: wb_regWrite <= ex_regWrite;
              w_ill: begin
                err_o    <= 1'b1;
                err_code <= LSU_ERR_ILLEGAL;
              end
              w_mal: begin
                err_o    <= 1'b1;
                err_code <= LSU_ERR_MISALIGN;
              end
              w_go: begin
                wb_valid <= 1'b0;
                r_state  <= ACCESS;
                r_wait   <= '0;
                r_req    <= '{
                  addr:  ex_alu_result,
                  we:    ex_memWrite,
                  regwr: ex_regWrite,
                  be:    ex_memWrite
                         ? st_be(ex_funct3, ex_alu_result[1:0])
                         : 4'b1111,
                  wdata: ex_memWrite
                         ? st_wdata(ex_funct3, ex_s_data)
                         : 32'd0,
                  rd:    ex_rd,
                  f3:    ex_funct3
                };
              end
            endcase
          end
        end
        ACCESS: begin
          wb_valid <= 1'b0;
          if (dmem_ack) begin
            r_state     <= IDLE;
            wb_valid    <= 1'b1;
            wb_rd       <= r_req.rd;
            wb_regWrite <= r_req.regwr & ~r_req.we;
            wb_memRead  <= ~r_req.we;
            wb_data     <= r_req.we ? r_req.addr : w_ld;
          end else if (r_wait == LAST) begin
            r_state     <= IDLE;
            wb_valid    <= 1'b1;
            wb_regWrite <= 1'b0;
            wb_memRead  <= 1'b0;
            wb_rd       <= r_req.rd;
            err_o       <= 1'b1;
            err_code    <= LSU_ERR_TIMEOUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Table-driven bench for mem_stage_lsu with a writeback scoreboard
// and a variable-latency memory responder.
module tb_mem_stage_lsu;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_regWrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_s_data;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_regWrite, wb_memRead;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_o;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_s_data(ex_s_data),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_regWrite(wb_regWrite), .wb_memRead(wb_memRead),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .err_o(err_o), .err_code(err_code)
  );

  typedef struct {
    string       name;
    logic        rdop, wrop, rw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, rdata;
    int          lat;
    int          nreq;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_rw, e_mr, e_err;
    logic [1:0]  e_code;
    logic        chk_d;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic        rw, mr, err;
    logic [1:0]  code;
    logic        chk_d;
    logic [31:0] data;
  } wb_exp_t;

  vec_t    tbl [17];
  vec_t    cur;
  wb_exp_t sbq [$];
  int      n_checks = 0;
  int      n_err    = 0;
  int      n_req, n_stall;
  logic    spur = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    wb_exp_t e;
    if (reset) begin
      dmem_ack = 1'b0;
      return;
    end
    if (dmem_req) begin
      n_req++;
      chk({cur.name, ".req_addr"}, dmem_addr, cur.e_addr);
      chk({cur.name, ".req_we"}, 32'(dmem_we), 32'(cur.wrop));
      chk({cur.name, ".req_be"}, 32'(dmem_be), 32'(cur.e_be));
      chk({cur.name, ".req_wdata"}, dmem_wdata, cur.e_wdata);
      dmem_ack   = (cur.lat != 0) && (n_req == cur.lat);
      dmem_rdata = cur.rdata;
    end else begin
      dmem_ack = spur;
    end
    if (stall_o) n_stall++;
    if (err_o && !wb_valid)
      chk("err_without_wb", 32'(err_o), 32'd0);
    if (wb_valid) begin
      if (sbq.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, ".wb_rw"}, 32'(wb_regWrite), 32'(e.rw));
        chk({e.name, ".err_o"}, 32'(err_o), 32'(e.err));
        if (e.err)
          chk({e.name, ".err_code"}, 32'(err_code), 32'(e.code));
        else begin
          chk({e.name, ".wb_mr"}, 32'(wb_memRead), 32'(e.mr));
          chk({e.name, ".wb_rd"}, 32'(wb_rd), 32'(e.rd));
        end
        if (e.chk_d)
          chk({e.name, ".wb_data"}, wb_data, e.data);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    wb_exp_t e;
    int k;
    cur     = v;
    n_req   = 0;
    n_stall = 0;
    ex_valid      = 1'b1;
    ex_memRead    = v.rdop;
    ex_memWrite   = v.wrop;
    ex_regWrite   = v.rw;
    ex_funct3     = v.f3;
    ex_rd         = v.rd;
    ex_alu_result = v.addr;
    ex_s_data     = v.sdata;
    e = '{v.name, v.rd, v.e_rw, v.e_mr, v.e_err, v.e_code,
          v.chk_d, v.e_data};
    sbq.push_back(e);
    cyc();
    ex_valid = 1'b0;
    k = 0;
    while (sbq.size() != 0 && k < 30) begin
      cyc();
      k++;
    end
    if (sbq.size() != 0) begin
      chk({v.name, ".wb_timeout"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    chk({v.name, ".req_cycles"}, 32'(n_req), 32'(v.nreq));
    chk({v.name, ".stall_cycles"}, 32'(n_stall), 32'(v.nreq));
    chk({v.name, ".idle_after"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{"sw",     0,1,0, 3'd2, 5'd0,  32'h100, 32'hDEADBEEF, 32'h0,
                3, 3, 32'h100, 32'hDEADBEEF, 4'hF, 0,0,0, 2'd0, 0, 32'h0};
    tbl[1]  = '{"sb",     0,1,0, 3'd0, 5'd0,  32'h103, 32'h000000AB, 32'h0,
                2, 2, 32'h100, 32'hABABABAB, 4'h8, 0,0,0, 2'd0, 0, 32'h0};
    tbl[2]  = '{"sh",     0,1,0, 3'd1, 5'd0,  32'h102, 32'h00001234, 32'h0,
                1, 1, 32'h100, 32'h12341234, 4'hC, 0,0,0, 2'd0, 0, 32'h0};
    tbl[3]  = '{"lb",     1,0,1, 3'd0, 5'd3,  32'h202, 32'h0, 32'h12F45678,
                2, 2, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'hFFFFFFF4};
    tbl[4]  = '{"lbu",    1,0,1, 3'd4, 5'd4,  32'h202, 32'h0, 32'h12F45678,
                2, 2, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'h000000F4};
    tbl[5]  = '{"lh",     1,0,1, 3'd1, 5'd5,  32'h202, 32'h0, 32'h12F45678,
                2, 2, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'h000012F4};
    tbl[6]  = '{"lhu",    1,0,1, 3'd5, 5'd6,  32'h202, 32'h0, 32'h12F45678,
                2, 2, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'h000012F4};
    tbl[7]  = '{"lw",     1,0,1, 3'd2, 5'd7,  32'h300, 32'h0, 32'hCAFEF00D,
                1, 1, 32'h300, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'hCAFEF00D};
    tbl[8]  = '{"lb_off1",1,0,1, 3'd0, 5'd8,  32'h201, 32'h0, 32'h12F45678,
                1, 1, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'h00000056};
    tbl[9]  = '{"lh_neg", 1,0,1, 3'd1, 5'd9,  32'h200, 32'h0, 32'h12348765,
                2, 2, 32'h200, 32'h0, 4'hF, 1,1,0, 2'd0, 1, 32'hFFFF8765};
    tbl[10] = '{"lw_mis", 1,0,1, 3'd2, 5'd10, 32'h301, 32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 0,0,1, 2'd0, 0, 32'h0};
    tbl[11] = '{"lh_mis", 1,0,1, 3'd1, 5'd11, 32'h203, 32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 0,0,1, 2'd0, 0, 32'h0};
    tbl[12] = '{"rd_wr",  1,1,1, 3'd2, 5'd12, 32'h100, 32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 0,0,1, 2'd1, 0, 32'h0};
    tbl[13] = '{"ld_f3",  1,0,1, 3'd3, 5'd13, 32'h100, 32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 0,0,1, 2'd1, 0, 32'h0};
    tbl[14] = '{"st_f3",  0,1,0, 3'd4, 5'd0,  32'h100, 32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 0,0,1, 2'd1, 0, 32'h0};
    tbl[15] = '{"add",    0,0,1, 3'd0, 5'd5,  32'h55,  32'h0, 32'h0,
                0, 0, 32'h0, 32'h0, 4'h0, 1,0,0, 2'd0, 1, 32'h55};
    tbl[16] = '{"tmo",    1,0,1, 3'd2, 5'd16, 32'h400, 32'h0, 32'h0,
                0, MW, 32'h400, 32'h0, 4'hF, 0,0,1, 2'd2, 0, 32'h0};

    reset = 1'b1;
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
    ex_regWrite = 1'b0; ex_funct3 = '0; ex_rd = '0;
    ex_alu_result = '0; ex_s_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    cur = tbl[15];
    n_req = 0; n_stall = 0;
    cyc();
    cyc();
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 17; i++) run_vec(tbl[i]);

    // Stray acks while idle must not start or finish anything.
    n_req = 0; n_stall = 0;
    spur = 1'b1;
    cyc(); cyc(); cyc();
    spur = 1'b0;
    cyc();
    chk("spur.req_cycles", 32'(n_req), 32'd0);
    chk("spur.stall_cycles", 32'(n_stall), 32'd0);
    chk("spur.wb_valid", 32'(wb_valid), 32'd0);

    // Reset in the middle of an access abandons it at once.
    cur = tbl[16];
    cur.name = "mid_rst";
    n_req = 0; n_stall = 0;
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_memWrite = 1'b0;
    ex_regWrite = 1'b1; ex_funct3 = 3'd2; ex_rd = 5'd16;
    ex_alu_result = 32'h400;
    cyc();
    ex_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_rst.req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst.req", 32'(dmem_req), 32'd0);
    chk("mid_rst.stall", 32'(stall_o), 32'd0);
    chk("mid_rst.addr", dmem_addr, 32'd0);
    chk("mid_rst.be", 32'(dmem_be), 32'd0);
    chk("mid_rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst.wb_rd", 32'(wb_rd), 32'd0);
    sbq.delete();
    cyc();
    reset = 1'b0;
    cyc();
    run_vec(tbl[15]);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
